// File: rtl/fle_config_loader.sv
// Configuration loader for one FLE: streams words into a shadow image and commits it atomically.
// Optional word parity checking with an ERR state is enabled by defining FLE_CFG_PARITY_EN.
module fle_config_loader #(
    parameter int unsigned NUM_BITS = 47,
    parameter int unsigned WORD_W   = 8
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WORD_W-1:0]   cfg_data,
`ifdef FLE_CFG_PARITY_EN
    input  logic                cfg_parity,
`endif
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                fabric_en,
    output logic [NUM_BITS-1:0] mem_out,
    output logic [NUM_BITS-1:0] mem_outb
);

    localparam int unsigned NUM_WORDS = (NUM_BITS + WORD_W - 1) / WORD_W;
    localparam int unsigned PAD_W     = NUM_WORDS * WORD_W;
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
`ifdef FLE_CFG_PARITY_EN
    localparam logic [1:0] ST_ERR    = 2'd3;
`endif

    logic [1:0]          state, state_nxt;
    logic [CNT_W-1:0]    word_cnt, word_cnt_nxt;
    logic [NUM_BITS-1:0] shadow, shadow_nxt;
    logic [NUM_BITS-1:0] mem_nxt;
    logic                fabric_en_nxt;
    logic                done_nxt;
    logic                parity_ok;
    logic [NUM_BITS-1:0] word_mask;
    logic [NUM_BITS-1:0] word_bits;

`ifdef FLE_CFG_PARITY_EN
    logic err_q, err_nxt;
    assign parity_ok = ~(^{cfg_data, cfg_parity});
    assign cfg_err   = err_q;
`else
    assign parity_ok = 1'b1;
    assign cfg_err   = 1'b0;
`endif

    // Word lane positioned at word_cnt*WORD_W; lanes beyond NUM_BITS fall off in the truncation.
    assign word_mask = NUM_BITS'(PAD_W'({WORD_W{1'b1}}) << (32'(word_cnt) * WORD_W));
    assign word_bits = NUM_BITS'(PAD_W'(cfg_data) << (32'(word_cnt) * WORD_W));

    assign cfg_ready = (state == ST_LOAD);
    assign cfg_busy  = (state != ST_IDLE);
    assign mem_outb  = ~mem_out;

    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        shadow_nxt    = shadow;
        mem_nxt       = mem_out;
        fabric_en_nxt = fabric_en;
        done_nxt      = 1'b0;
`ifdef FLE_CFG_PARITY_EN
        err_nxt       = err_q;
`endif
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt     = ST_LOAD;
                    word_cnt_nxt  = '0;
                    shadow_nxt    = '0;
                    fabric_en_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    word_cnt_nxt = '0;
                    shadow_nxt   = '0;
                end else if (cfg_valid) begin
                    if (!parity_ok) begin
`ifdef FLE_CFG_PARITY_EN
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
`endif
                    end else begin
                        shadow_nxt = (shadow & ~word_mask) | word_bits;
                        if (word_cnt == CNT_W'(NUM_WORDS - 1)) begin
                            state_nxt = ST_COMMIT;
                        end else begin
                            word_cnt_nxt = word_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_COMMIT: begin
                mem_nxt       = shadow;
                done_nxt      = 1'b1;
                fabric_en_nxt = 1'b1;
                state_nxt     = ST_IDLE;
            end
`ifdef FLE_CFG_PARITY_EN
            ST_ERR: begin
                if (cfg_start) begin
                    state_nxt     = ST_LOAD;
                    err_nxt       = 1'b0;
                    word_cnt_nxt  = '0;
                    shadow_nxt    = '0;
                    fabric_en_nxt = 1'b0;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            shadow    <= '0;
            mem_out   <= '0;
            fabric_en <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            shadow    <= shadow_nxt;
            mem_out   <= mem_nxt;
            fabric_en <= fabric_en_nxt;
            cfg_done  <= done_nxt;
        end
    end

`ifdef FLE_CFG_PARITY_EN
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fle_config_loader.sv
// Scoreboard bench for fle_config_loader: committed images are queued at stimulus time and
// retired on cfg_done; mem_out/mem_outb are compared against the bench model every cycle.
module tb_fle_config_loader;

    localparam int unsigned NUM_BITS  = 47;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned NUM_WORDS = 6;

    logic                prog_clk   = 1'b0;
    logic                prog_reset = 1'b1;
    logic                cfg_start  = 1'b0;
    logic                cfg_valid  = 1'b0;
    logic [WORD_W-1:0]   cfg_data   = '0;
    logic                cfg_parity = 1'b0;
    logic                cfg_ready;
    logic                cfg_busy;
    logic                cfg_done;
    logic                cfg_err;
    logic                fabric_en;
    logic [NUM_BITS-1:0] mem_out;
    logic [NUM_BITS-1:0] mem_outb;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [NUM_BITS-1:0] sb_q[$];
    logic [NUM_BITS-1:0] exp_mem = '0;

    always #5 prog_clk = ~prog_clk;

    fle_config_loader #(
        .NUM_BITS (NUM_BITS),
        .WORD_W   (WORD_W)
    ) u_dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
`ifdef FLE_CFG_PARITY_EN
        .cfg_parity (cfg_parity),
`endif
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .fabric_en  (fabric_en),
        .mem_out    (mem_out),
        .mem_outb   (mem_outb)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Retire scoreboard entries on cfg_done and track the image mem_out must show.
    always @(negedge prog_clk) begin
        logic [NUM_BITS-1:0] inv;
        if (!prog_reset && cfg_done) begin
            if (sb_q.size() == 0) check_eq("sb_unexpected_done", 64'(cfg_done), 64'(0));
            else exp_mem = sb_q.pop_front();
        end
        inv = ~exp_mem;
        check_eq("mem_out", 64'(mem_out), 64'(exp_mem));
        check_eq("mem_outb", 64'(mem_outb), 64'(inv));
    end

    task automatic start_load();
        cfg_start = 1'b1;
        @(posedge prog_clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input bit bad_par);
        logic r;
        bit   got;
        got        = 1'b0;
        cfg_valid  = 1'b1;
        cfg_data   = d;
        cfg_parity = bad_par ? ~(^d) : ^d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge prog_clk);
            r = cfg_ready;
            @(posedge prog_clk); #1;
            if (r) got = 1'b1;
        end
        if (!got) check_eq("handshake_timeout", 64'(cfg_ready), 64'(1));
    endtask

    task automatic load_words(input logic [8*NUM_WORDS-1:0] words, input bit do_start, input bit gaps);
        logic [WORD_W-1:0] b;
        if (do_start) start_load();
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge prog_clk); #1;
                end
            end
            b = WORD_W'(words >> (WORD_W * w));
            if (w == NUM_WORDS - 1) sb_q.push_back(words[NUM_BITS-1:0]);
            send_word(b, 1'b0);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_commit();
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge prog_clk);
        check_eq("commit_pending", 64'(sb_q.size()), 64'(0));
        @(posedge prog_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8*NUM_WORDS-1:0] rnd;

        // Reset applied asynchronously before any clock edge
        #2;
        check_eq("rst_mem_out", 64'(mem_out), 64'(0));
        check_eq("rst_mem_outb", 64'(mem_outb), 64'(47'h7FFF_FFFF_FFFF));
        check_eq("rst_fabric_en", 64'(fabric_en), 64'(0));
        check_eq("rst_ready", 64'(cfg_ready), 64'(0));
        check_eq("rst_busy", 64'(cfg_busy), 64'(0));
        check_eq("rst_done", 64'(cfg_done), 64'(0));
        check_eq("rst_err", 64'(cfg_err), 64'(0));
        @(negedge prog_clk); #2;
        prog_reset = 1'b0;
        @(posedge prog_clk); #1;

        // Full back-to-back load with exact commit latency
        load_words({NUM_WORDS{8'hA5}}, 1'b1, 1'b0);
        @(negedge prog_clk);
        check_eq("t2_commit_busy", 64'(cfg_busy), 64'(1));
        check_eq("t2_done_early", 64'(cfg_done), 64'(0));
        check_eq("t2_fabric_early", 64'(fabric_en), 64'(0));
        @(negedge prog_clk);
        check_eq("t2_done", 64'(cfg_done), 64'(1));
        check_eq("t2_fabric_en", 64'(fabric_en), 64'(1));
        check_eq("t2_image", 64'(mem_out), 64'(47'h25A5_A5A5_A5A5));
        check_eq("t2_idle", 64'(cfg_busy), 64'(0));
        @(negedge prog_clk);
        check_eq("t2_done_pulse", 64'(cfg_done), 64'(0));
        check_eq("t2_fabric_hold", 64'(fabric_en), 64'(1));
        @(posedge prog_clk); #1;

        // cfg_valid in IDLE has no effect
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        repeat (3) begin
            @(posedge prog_clk); #1;
        end
        @(negedge prog_clk);
        check_eq("t3_idle_busy", 64'(cfg_busy), 64'(0));
        check_eq("t3_idle_ready", 64'(cfg_ready), 64'(0));
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;

        // Same data with random gaps
        load_words({NUM_WORDS{8'hA5}}, 1'b1, 1'b1);
        wait_commit();
        check_eq("t3_fabric_en", 64'(fabric_en), 64'(1));

        // Restart after 3 words, with cfg_valid high alongside cfg_start
        start_load();
        check_eq("t4_fabric_off", 64'(fabric_en), 64'(0));
        for (int w = 0; w < 3; w++) send_word(8'hFF, 1'b0);
        cfg_start = 1'b1;
        @(posedge prog_clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        check_eq("t4_restart_ready", 64'(cfg_ready), 64'(1));
        check_eq("t4_restart_fabric", 64'(fabric_en), 64'(0));
        @(posedge prog_clk); #1;
        load_words('0, 1'b0, 1'b0);
        @(negedge prog_clk);
        check_eq("t4_reload_fabric", 64'(fabric_en), 64'(0));
        wait_commit();
        check_eq("t4_fabric_en", 64'(fabric_en), 64'(1));

`ifdef FLE_CFG_PARITY_EN
        // Bad parity on word 2 aborts the load
        start_load();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b1);
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        check_eq("t5_err", 64'(cfg_err), 64'(1));
        check_eq("t5_ready", 64'(cfg_ready), 64'(0));
        check_eq("t5_busy", 64'(cfg_busy), 64'(1));
        check_eq("t5_fabric", 64'(fabric_en), 64'(0));
        repeat (3) @(negedge prog_clk);
        check_eq("t5_no_commit", 64'(cfg_done), 64'(0));
        @(posedge prog_clk); #1;
        start_load();
        @(negedge prog_clk);
        check_eq("t5_err_clear", 64'(cfg_err), 64'(0));
        @(posedge prog_clk); #1;
        load_words(48'h6655_4433_2211, 1'b0, 1'b0);
        wait_commit();
        check_eq("t5_fabric_en", 64'(fabric_en), 64'(1));
`endif

        // Reset in the middle of a load
        start_load();
        for (int w = 0; w < 4; w++) send_word(8'h3C, 1'b0);
        cfg_valid = 1'b0;
        @(negedge prog_clk); #2;
        prog_reset = 1'b1;
        exp_mem    = '0;
        #1;
        check_eq("t6_mem_out", 64'(mem_out), 64'(0));
        check_eq("t6_mem_outb", 64'(mem_outb), 64'(47'h7FFF_FFFF_FFFF));
        check_eq("t6_fabric_en", 64'(fabric_en), 64'(0));
        check_eq("t6_busy", 64'(cfg_busy), 64'(0));
        check_eq("t6_ready", 64'(cfg_ready), 64'(0));
        @(negedge prog_clk); #2;
        prog_reset = 1'b0;
        @(posedge prog_clk); #1;
        load_words(48'h0123_4567_89AB, 1'b1, 1'b0);
        wait_commit();
        check_eq("t6_fabric_en_after", 64'(fabric_en), 64'(1));

        // Random images, some with gaps
        for (int k = 0; k < 4; k++) begin
            rnd = {16'($urandom), $urandom};
            load_words(rnd, 1'b1, k[0]);
            wait_commit();
        end

        repeat (2) @(negedge prog_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
